// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between a CPU and a DMA engine. The CPU
// always has an access pending; the DMA engine raises dma_req and holds it
// (with its operands) until dma_ack. Each access runs through an ACC phase
// of MEM_LAT+1 cycles, then a one-cycle ACK phase. The ACK phase strobes
// cpu_clk_en or dma_ack and is also where the next grant is chosen.
//
// Build option:
//   MEM_ARB_DMA_PRIORITY_EN - when defined, a pending DMA request wins every
//                             grant decision. When undefined, grants
//                             alternate: DMA only follows a CPU grant.
//
// Parameters:
//   MEM_LAT     - cycles from mem_addr/mem_en valid to mem_rd_data valid (1..4)
//
// Ports:
//   clk         - single clock, all state changes on the rising edge
//   rst         - synchronous active-high reset
//   cpu_addr    - CPU address (16)
//   cpu_wr_data - CPU write data (8)
//   cpu_rw_n    - CPU direction, 1 = read
//   cpu_rd_data - last data read for the CPU (8), held between reads
//   cpu_clk_en  - one-cycle CPU advance strobe, once per CPU access
//   dma_req     - DMA request
//   dma_addr    - DMA address (16)
//   dma_wr_data - DMA write data (8)
//   dma_rw_n    - DMA direction, 1 = read
//   dma_ack     - one-cycle DMA completion strobe
//   dma_rd_data - last data read for the DMA engine (8)
//   mem_addr    - memory address (16)
//   mem_wr_data - memory write data (8)
//   mem_en      - memory enable, high for the whole ACC phase
//   mem_we      - memory write enable, high during ACC of a write
//   mem_rd_data - memory read data (8)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rw_n,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_clk_en,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wr_data,
    input  logic        dma_rw_n,
    output logic        dma_ack,
    output logic [7:0]  dma_rd_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wr_data,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [7:0]  mem_rd_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CPU_ACC = 3'd1;
    localparam logic [2:0] CPU_ACK = 3'd2;
    localparam logic [2:0] DMA_ACC = 3'd3;
    localparam logic [2:0] DMA_ACK = 3'd4;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);

    logic [2:0] state;
    logic [2:0] lat_cnt;
    logic       last_dma;
    logic       grant_dma;

    // Grant choice for the current decision cycle. With the priority option
    // a pending DMA request always wins and can stall the CPU indefinitely;
    // otherwise DMA may only follow a CPU grant, which bounds the DMA wait
    // to one CPU access and keeps the CPU from starving.
    always_comb begin
`ifdef MEM_ARB_DMA_PRIORITY_EN
        grant_dma = dma_req;
`else
        grant_dma = dma_req && !last_dma;
`endif
    end

    // Main sequencer. Every output is a register, so each output is set on
    // the edge that enters the state it belongs to. The latched operands
    // live directly in mem_addr/mem_wr_data/mem_we. They freeze the access
    // against later input changes. A read is recognised at completion by
    // mem_we being low. The ACK states double as decision points, so
    // back-to-back accesses need no extra IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_dma    <= 1'b1;
            lat_cnt     <= 3'd0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wr_data <= 8'h00;
            cpu_clk_en  <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rd_data <= 8'h00;
            dma_rd_data <= 8'h00;
        end else begin
            cpu_clk_en <= 1'b0;
            dma_ack    <= 1'b0;
            case (state)
                IDLE, CPU_ACK, DMA_ACK: begin
                    lat_cnt  <= 3'd0;
                    mem_en   <= 1'b1;
                    last_dma <= grant_dma;
                    if (grant_dma) begin
                        state       <= DMA_ACC;
                        mem_addr    <= dma_addr;
                        mem_wr_data <= dma_wr_data;
                        mem_we      <= ~dma_rw_n;
                    end else begin
                        state       <= CPU_ACC;
                        mem_addr    <= cpu_addr;
                        mem_wr_data <= cpu_wr_data;
                        mem_we      <= ~cpu_rw_n;
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    if (lat_cnt == LAT_LAST) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == CPU_ACC) begin
                            state      <= CPU_ACK;
                            cpu_clk_en <= 1'b1;
                            if (!mem_we) begin
                                cpu_rd_data <= mem_rd_data;
                            end
                        end else begin
                            state   <= DMA_ACK;
                            dma_ack <= 1'b1;
                            if (!mem_we) begin
                                dma_rd_data <= mem_rd_data;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
